// File: rtl/nib_pack.sv
// Round-robin nibble packer: three W-bit lanes are merged into 2W-bit bytes
// and queued in a small FIFO, with flush to pad out a trailing half byte.
module nib_pack #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               l1_dat,
    input  logic [W-1:0]               l2_dat,
    input  logic [W-1:0]               l3_dat,
    input  logic                       l1_vld,
    input  logic                       l2_vld,
    input  logic                       l3_vld,
    output logic                       l1_rdy,
    output logic                       l2_rdy,
    output logic                       l3_rdy,
    input  logic                       flush,
    output logic [2*W-1:0]             out_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = 2 * W;

    logic [1:0]    ptr_q, ptr_d;
    logic          half_q, half_d;
    logic [W-1:0]  low_q, low_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] mem_q [DEPTH];

    logic [2:0]    vld, rot, pick, gnt;
    logic          full, empty, block, any_gnt, flush_svc, push, pop;
    logic [W-1:0]  gdat;
    logic [BW-1:0] wr_byte;

    assign vld   = {l3_vld, l2_vld, l1_vld};
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == CW'(0));

    // A pending flush is serviced once the FIFO had room at the start of the cycle.
    assign flush_svc = half_q && !full && (pend_q || flush);
    assign block     = rst || flush || pend_q || (half_q && full);

    // Rotate so the pointer lane sits at bit 0, pick lowest, rotate back.
    always_comb begin
        rot = vld;
        unique case (ptr_q)
            2'd2:    rot = {vld[0], vld[2], vld[1]};
            2'd3:    rot = {vld[1], vld[0], vld[2]};
            default: rot = vld;
        endcase
        if (rot[0])      pick = 3'b001;
        else if (rot[1]) pick = 3'b010;
        else if (rot[2]) pick = 3'b100;
        else             pick = 3'b000;
        gnt = pick;
        unique case (ptr_q)
            2'd2:    gnt = {pick[1], pick[0], pick[2]};
            2'd3:    gnt = {pick[0], pick[2], pick[1]};
            default: gnt = pick;
        endcase
        if (block) gnt = 3'b000;
    end

    assign any_gnt = |gnt;
    assign l1_rdy  = gnt[0];
    assign l2_rdy  = gnt[1];
    assign l3_rdy  = gnt[2];

    always_comb begin
        gdat = l1_dat;
        if (gnt[1])      gdat = l2_dat;
        else if (gnt[2]) gdat = l3_dat;
    end

    assign push    = flush_svc || (any_gnt && half_q);
    assign pop     = !empty && out_rdy;
    assign wr_byte = flush_svc ? {W'(0), low_q} : {gdat, low_q};

    always_comb begin
        ptr_d  = ptr_q;
        half_d = half_q;
        low_d  = low_q;
        pend_d = pend_q ? full : (flush && half_q && full);
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d  = cnt_q;
        if (gnt[0]) ptr_d = 2'd2;
        if (gnt[1]) ptr_d = 2'd3;
        if (gnt[2]) ptr_d = 2'd1;
        if (flush_svc) begin
            half_d = 1'b0;
        end else if (any_gnt) begin
            half_d = !half_q;
            if (!half_q) low_d = gdat;
        end
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= 2'd1;
            half_q <= 1'b0;
            low_q  <= '0;
            pend_q <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            ptr_q  <= ptr_d;
            half_q <= half_d;
            low_q  <= low_d;
            pend_q <= pend_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wr_q] <= wr_byte;
        end
    end

    assign out_vld = !empty;
    assign out_dat = empty ? '0 : mem_q[rd_q];
    assign cnt     = cnt_q;
endmodule

// File: tb/tb_nib_pack.sv
// Directed table-driven bench for nib_pack (W=4, DEPTH=4).
module tb_nib_pack;
    logic       clk, rst;
    logic [3:0] l1_dat, l2_dat, l3_dat;
    logic       l1_vld, l2_vld, l3_vld;
    logic       l1_rdy, l2_rdy, l3_rdy;
    logic       flush, out_vld, out_rdy;
    logic [7:0] out_dat;
    logic [2:0] cnt;

    int total = 0;
    int bad   = 0;

    nib_pack #(.W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .l1_dat(l1_dat), .l2_dat(l2_dat), .l3_dat(l3_dat),
        .l1_vld(l1_vld), .l2_vld(l2_vld), .l3_vld(l3_vld),
        .l1_rdy(l1_rdy), .l2_rdy(l2_rdy), .l3_rdy(l3_rdy),
        .flush(flush), .out_dat(out_dat), .out_vld(out_vld),
        .out_rdy(out_rdy), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // vld/erdy packed as {l3,l2,l1}; expectations describe state before this cycle's edge
    typedef struct {
        bit         rst;
        logic [2:0] vld;
        logic [3:0] d1, d2, d3;
        logic       fl, ordy;
        logic [2:0] erdy;
        logic [2:0] ecnt;
        logic [7:0] edat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [2:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic f, input logic o, input logic [2:0] er,
                       input logic [2:0] ec, input logic [7:0] ed);
        vec_t x;
        x.rst = r; x.vld = v; x.d1 = a; x.d2 = b; x.d3 = c; x.fl = f; x.ordy = o;
        x.erdy = er; x.ecnt = ec; x.edat = ed;
        tbl.push_back(x);
    endtask

    task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic [2:0] erdy, input logic [2:0] ecnt,
                              input logic [7:0] edat);
        check("rdy", idx, {5'b0, l3_rdy, l2_rdy, l1_rdy}, {5'b0, erdy});
        check("cnt", idx, 8'(cnt), 8'(ecnt));
        check("out_vld", idx, 8'(out_vld), 8'(ecnt != 3'd0));
        check("out_dat", idx, out_dat, edat);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        if (v.rst) begin
            rst = 1'b1;
            #1;
            rst = 1'b0;
        end
        {l3_vld, l2_vld, l1_vld} = v.vld;
        l1_dat = v.d1; l2_dat = v.d2; l3_dat = v.d3;
        flush = v.fl; out_rdy = v.ordy;
        #1;
        check_outs(idx, v.erdy, v.ecnt, v.edat);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_rdy = 1'b0;
        l1_dat = 4'h0; l2_dat = 4'h0; l3_dat = 4'h0;
        {l3_vld, l2_vld, l1_vld} = 3'b111;
        #3;
        check_outs(-1, 3'b000, 3'd0, 8'h00);
        {l3_vld, l2_vld, l1_vld} = 3'b000;
        @(negedge clk);
        rst = 1'b0;

        // single-lane packing
        add(0, 3'b010, 4'h0, 4'h3, 4'h0, 0, 1, 3'b010, 3'd0, 8'h00);
        add(0, 3'b010, 4'h0, 4'hA, 4'h0, 0, 1, 3'b010, 3'd0, 8'h00);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd1, 8'hA3);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd0, 8'h00);
        // round robin from reset
        add(1, 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 3'b001, 3'd0, 8'h00);
        add(0, 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 3'b010, 3'd0, 8'h00);
        add(0, 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 3'b100, 3'd1, 8'h21);
        add(0, 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 3'b001, 3'd0, 8'h00);
        add(0, 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 3'b010, 3'd1, 8'h13);
        add(0, 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 3'b100, 3'd0, 8'h00);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, 3'b000, 3'd1, 8'h32);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd1, 8'h32);
        // backpressure: fill, stall on half byte, single pop
        add(0, 3'b001, 4'h4, 4'h0, 4'h0, 0, 0, 3'b001, 3'd0, 8'h00);
        add(0, 3'b001, 4'h5, 4'h0, 4'h0, 0, 0, 3'b001, 3'd0, 8'h00);
        add(0, 3'b001, 4'h6, 4'h0, 4'h0, 0, 0, 3'b001, 3'd1, 8'h54);
        add(0, 3'b001, 4'h7, 4'h0, 4'h0, 0, 0, 3'b001, 3'd1, 8'h54);
        add(0, 3'b001, 4'h8, 4'h0, 4'h0, 0, 0, 3'b001, 3'd2, 8'h54);
        add(0, 3'b001, 4'h9, 4'h0, 4'h0, 0, 0, 3'b001, 3'd2, 8'h54);
        add(0, 3'b001, 4'hA, 4'h0, 4'h0, 0, 0, 3'b001, 3'd3, 8'h54);
        add(0, 3'b001, 4'hB, 4'h0, 4'h0, 0, 0, 3'b001, 3'd3, 8'h54);
        add(0, 3'b001, 4'hC, 4'h0, 4'h0, 0, 0, 3'b001, 3'd4, 8'h54);
        add(0, 3'b001, 4'hD, 4'h0, 4'h0, 0, 0, 3'b000, 3'd4, 8'h54);
        add(0, 3'b001, 4'hD, 4'h0, 4'h0, 0, 1, 3'b000, 3'd4, 8'h54);
        add(0, 3'b001, 4'hD, 4'h0, 4'h0, 0, 0, 3'b001, 3'd3, 8'h76);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, 3'b000, 3'd4, 8'h76);
        // pending flush while full
        add(0, 3'b001, 4'h7, 4'h0, 4'h0, 0, 0, 3'b001, 3'd4, 8'h76);
        add(0, 3'b001, 4'hE, 4'h0, 4'h0, 1, 0, 3'b000, 3'd4, 8'h76);
        add(0, 3'b001, 4'hE, 4'h0, 4'h0, 0, 0, 3'b000, 3'd4, 8'h76);
        add(0, 3'b001, 4'hE, 4'h0, 4'h0, 1, 0, 3'b000, 3'd4, 8'h76);
        add(0, 3'b001, 4'hE, 4'h0, 4'h0, 0, 1, 3'b000, 3'd4, 8'h76);
        add(0, 3'b001, 4'hE, 4'h0, 4'h0, 0, 0, 3'b000, 3'd3, 8'h98);
        add(0, 3'b001, 4'hE, 4'h0, 4'h0, 0, 0, 3'b001, 3'd4, 8'h98);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd4, 8'h98);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd3, 8'hBA);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd2, 8'hDC);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd1, 8'h07);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, 3'b000, 3'd0, 8'h00);
        // plain flush with and without a half byte
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 1, 0, 3'b000, 3'd0, 8'h00);
        add(0, 3'b001, 4'h5, 4'h0, 4'h0, 0, 0, 3'b001, 3'd1, 8'h0E);
        add(0, 3'b001, 4'h6, 4'h0, 4'h0, 1, 0, 3'b000, 3'd1, 8'h0E);
        add(0, 3'b001, 4'h6, 4'h0, 4'h0, 1, 0, 3'b000, 3'd2, 8'h0E);
        add(0, 3'b001, 4'h6, 4'h0, 4'h0, 0, 0, 3'b001, 3'd2, 8'h0E);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd2, 8'h0E);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 1, 3'b000, 3'd1, 8'h05);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, 3'b000, 3'd0, 8'h00);
        // empty pop ignored, then simultaneous push and pop
        add(0, 3'b001, 4'h7, 4'h0, 4'h0, 0, 1, 3'b001, 3'd0, 8'h00);
        add(0, 3'b001, 4'h8, 4'h0, 4'h0, 0, 1, 3'b001, 3'd1, 8'h76);
        add(0, 3'b001, 4'h9, 4'h0, 4'h0, 0, 0, 3'b001, 3'd0, 8'h00);
        add(0, 3'b001, 4'h1, 4'h0, 4'h0, 0, 0, 3'b001, 3'd1, 8'h98);
        add(0, 3'b001, 4'h2, 4'h0, 4'h0, 0, 1, 3'b001, 3'd1, 8'h98);
        add(0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, 3'b000, 3'd1, 8'h21);
        // build cnt=3 with a half byte pending
        add(0, 3'b001, 4'h3, 4'h0, 4'h0, 0, 0, 3'b001, 3'd1, 8'h21);
        add(0, 3'b001, 4'h4, 4'h0, 4'h0, 0, 0, 3'b001, 3'd1, 8'h21);
        add(0, 3'b001, 4'h5, 4'h0, 4'h0, 0, 0, 3'b001, 3'd2, 8'h21);
        add(0, 3'b001, 4'h6, 4'h0, 4'h0, 0, 0, 3'b001, 3'd2, 8'h21);
        add(0, 3'b001, 4'h7, 4'h0, 4'h0, 0, 0, 3'b001, 3'd3, 8'h21);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // asynchronous reset mid-cycle, then first grants after release
        @(negedge clk);
        {l3_vld, l2_vld, l1_vld} = 3'b111;
        rst = 1'b1;
        #1;
        check_outs(100, 3'b000, 3'd0, 8'h00);
        #1;
        rst = 1'b0;
        l1_dat = 4'h1; l2_dat = 4'h9; l3_dat = 4'h8;
        {l3_vld, l2_vld, l1_vld} = 3'b110;
        #1;
        check_outs(101, 3'b010, 3'd0, 8'h00);
        @(negedge clk);
        {l3_vld, l2_vld, l1_vld} = 3'b111;
        #1;
        check_outs(102, 3'b100, 3'd0, 8'h00);
        @(negedge clk);
        {l3_vld, l2_vld, l1_vld} = 3'b000;
        #1;
        check_outs(103, 3'b000, 3'd1, 8'h89);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nib_pack.md
NIB_PACK -- requirements
Module: nib_pack

Interface
REQ-001 Parameter: W, default 4, width of each input lane nibble.
REQ-002 Parameter: DEPTH, default 4, output FIFO depth in bytes; power of two, 2 or greater.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: l1_dat, l2_dat, l3_dat  input  W each  lane data.
REQ-006 Port: l1_vld, l2_vld, l3_vld  input  1 each  lane data valid.
REQ-007 Port: l1_rdy, l2_rdy, l3_rdy  output  1 each  lane accept; a transfer occurs when lN_vld and lN_rdy are both high.
REQ-008 Port: flush  input  1  single-cycle pad-and-push request for a pending half byte.
REQ-009 Port: out_dat  output  2W  FIFO head byte.
REQ-010 Port: out_vld  output  1  FIFO non-empty.
REQ-011 Port: out_rdy  input  1  consumer accept; a pop occurs when out_vld and out_rdy are both high.
REQ-012 Port: cnt  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-013 The block SHALL assert at most one lN_rdy per cycle.
REQ-014 lN_rdy SHALL be combinational and SHALL be high only for the granted lane.
REQ-015 Grant rule: among lanes with vld high, grant the first one found starting at priority pointer ptr, in order ptr, ptr+1, ptr+2 (mod 3).
REQ-016 After a grant to lane k, ptr SHALL become (k mod 3)+1; with no grant, ptr SHALL hold.
REQ-017 No lane SHALL be granted when half=1 and the FIFO is full, or when a flush is being serviced or is pending.
REQ-018 Packer, half=0 case: an accepted nibble SHALL be stored as the low nibble and half SHALL be set to 1.
REQ-019 Packer, half=1 case: an accepted nibble SHALL form byte {new, low}, that byte SHALL be pushed to the FIFO, and half SHALL clear to 0.
REQ-020 Lane identity SHALL NOT affect packing order.
REQ-021 A pushed byte SHALL be visible on out_dat/out_vld on the cycle after the push (1-cycle latency).
REQ-022 The FIFO SHALL be first-in first-out, with wrap-around pointers modulo DEPTH.
REQ-023 A push and a pop in the same cycle SHALL be allowed when the FIFO is not full; cnt SHALL be unchanged in that case.
REQ-024 When the FIFO is full, a push SHALL NOT occur even if a pop occurs in the same cycle.
REQ-025 A pop when the FIFO is empty SHALL be ignored.
REQ-026 cnt SHALL increment on push only, decrement on pop only, and hold otherwise; cnt SHALL never exceed DEPTH or go below 0.
REQ-027 out_dat SHALL be 0 whenever the FIFO is empty.
REQ-028 Flush with half=1 and FIFO not full: push {0, low}, clear half; no lane grant in that cycle.
REQ-029 Flush with half=1 and FIFO full: set flush_pend; service it, per REQ-028, on the first cycle the FIFO is not full at the start of the cycle; grants stay blocked until then.
REQ-030 Flush with half=0: no effect, and no grant blocking beyond the flush cycle itself.
REQ-031 Flush while flush_pend is already set SHALL have no additional effect.

Reset
REQ-032 On rst high the block SHALL immediately, without waiting for clk, set: ptr=1, half=0, flush_pend=0, FIFO pointers=0, cnt=0, out_vld=0, out_dat=0, all lN_rdy=0.
REQ-033 Reset asserted mid-operation SHALL discard the pending half byte and all FIFO contents.
REQ-034 The first grant after reset release SHALL follow REQ-015 with ptr=1.

Verification
REQ-035 Scenario, packing: only l2 valid, data 0x3 then 0xA, out_rdy=1 -> one byte 0xA3 on out_dat the cycle after the second accept; cnt goes 1 then 0.
REQ-036 Scenario, round-robin: all three lanes valid every cycle with data 1, 2, 3 -> grants l1, l2, l3, l1, l2, l3; bytes 0x21, 0x13, 0x32.
REQ-037 Scenario, backpressure: out_rdy=0, l1 streaming, DEPTH=4 -> cnt reaches 4; l1_rdy drops with half=1; out_rdy=1 for one cycle -> exactly one pop, then one push on the following accept.
REQ-038 Scenario, flush: one nibble 0x5 then flush -> byte 0x05 pushed; flush with half=0 -> cnt unchanged.
REQ-039 Scenario, pending flush: FIFO full, half=1 (low 0x7), flush pulse -> flush_pend held, no grants; pop -> 0x07 pushed on the next cycle.
REQ-040 Scenario, reset: rst asserted asynchronously mid-stream with cnt=3 -> cnt=0, out_vld=0, all rdy=0 before the next clk edge; after release, first grant goes to the lowest-index valid lane starting from lane 1.
